// File: rtl/sad_pkg.sv
// Shared constants, FSM encoding and lane-slicing helper for the SAD operand feeder.
package sad_pkg;

  localparam int unsigned LANES   = 16;
  localparam int unsigned WIN_DIM = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WIN,
    ST_FETCH,
    ST_PRESENT,
    ST_FIN
  } state_e;

  // Lane k occupies bits [k*pix_w +: pix_w] of a packed lane bus.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned pix_w);
    return k * pix_w;
  endfunction

endpackage

// File: rtl/sad_fetch_addr_gen.sv
// Candidate-pixel address: base + (pos_y + idx/4)*FRAME_W + pos_x + idx%4, unsigned at ADDR_W bits.
module sad_fetch_addr_gen
  import sad_pkg::*;
#(
  parameter int unsigned FRAME_W = 64,
  parameter int unsigned ADDR_W  = 13
) (
  input  logic [3:0]        idx,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       pos_x,
  input  logic [15:0]       pos_y,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  always_comb begin
    row  = ADDR_W'(pos_y) + ADDR_W'(32'(idx) / WIN_DIM);
    col  = ADDR_W'(pos_x) + ADDR_W'(32'(idx) % WIN_DIM);
    addr = base + row * ADDR_W'(FRAME_W) + col;
  end

endmodule

// File: rtl/sad_operand_feeder.sv
// Loads a 4x4 reference window, then gathers every 4x4 candidate of the frame in raster
// order and presents window/candidate pixels as 16 lane pairs over valid/ready.
module sad_operand_feeder
  import sad_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FRAME_W    = 64,
  parameter int unsigned FRAME_H    = 64,
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned WIN_BASE   = 0,
  parameter int unsigned FRAME_BASE = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  output logic                   Busy,
  output logic                   Done,
  output logic                   MemRdEn,
  output logic [ADDR_W-1:0]      MemAddr,
  input  logic [PIX_W-1:0]       MemRdData,
  output logic [LANES*PIX_W-1:0] LaneA,
  output logic [LANES*PIX_W-1:0] LaneB,
  output logic [15:0]            PosX,
  output logic [15:0]            PosY,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic                   OutLast
);

  state_e                 state_q, state_d;
  logic [4:0]             iss_q, iss_d;
  logic [3:0]             cap_q, cap_d;
  logic                   rd_vld_q;
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [LANES*PIX_W-1:0] lane_a_q, lane_a_d;
  logic [LANES*PIX_W-1:0] lane_b_q, lane_b_d;
  logic [15:0]            pos_x_q, pos_x_d;
  logic [15:0]            pos_y_q, pos_y_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [3:0]             gen_idx;
  logic [ADDR_W-1:0]      fetch_addr;

  // Position update kept apart from the main next-state block so the address
  // generator can see the post-handshake position without a combinational cycle.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (state_q == ST_IDLE && Start) begin
      pos_x_d = '0;
      pos_y_d = '0;
    end else if (state_q == ST_PRESENT && OutReady && !out_last_q) begin
      if (pos_x_q == 16'(FRAME_W - 4)) begin
        pos_x_d = '0;
        pos_y_d = pos_y_q + 16'd1;
      end else begin
        pos_x_d = pos_x_q + 16'd1;
      end
    end
  end

  assign gen_idx = (state_q == ST_FETCH) ? iss_q[3:0] : 4'd0;

  sad_fetch_addr_gen #(
    .FRAME_W (FRAME_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .idx   (gen_idx),
    .base  (ADDR_W'(FRAME_BASE)),
    .pos_x (pos_x_d),
    .pos_y (pos_y_d),
    .addr  (fetch_addr)
  );

  always_comb begin
    state_d     = state_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    lane_a_d    = lane_a_q;
    lane_b_d    = lane_b_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d     = ST_LOAD_WIN;
          busy_d      = 1'b1;
          iss_d       = 5'd1;
          cap_d       = '0;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = ADDR_W'(WIN_BASE);
        end
      end
      ST_LOAD_WIN: begin
        if (iss_q < 5'(LANES)) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = ADDR_W'(WIN_BASE) + ADDR_W'(iss_q);
          iss_d       = iss_q + 5'd1;
        end
        if (rd_vld_q) begin
          lane_a_d[lane_lsb(32'(cap_q), PIX_W) +: PIX_W] = MemRdData;
          cap_d = cap_q + 4'd1;
          if (cap_q == 4'(LANES - 1)) begin
            state_d     = ST_FETCH;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = fetch_addr;
            iss_d       = 5'd1;
            cap_d       = '0;
          end
        end
      end
      ST_FETCH: begin
        if (iss_q < 5'(LANES)) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = fetch_addr;
          iss_d       = iss_q + 5'd1;
        end
        if (rd_vld_q) begin
          lane_b_d[lane_lsb(32'(cap_q), PIX_W) +: PIX_W] = MemRdData;
          cap_d = cap_q + 4'd1;
          if (cap_q == 4'(LANES - 1)) begin
            state_d     = ST_PRESENT;
            out_valid_d = 1'b1;
            out_last_d  = (pos_x_q == 16'(FRAME_W - 4)) && (pos_y_q == 16'(FRAME_H - 4));
          end
        end
      end
      ST_PRESENT: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_FETCH;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = fetch_addr;
            iss_d       = 5'd1;
            cap_d       = '0;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      iss_q       <= '0;
      cap_q       <= '0;
      rd_vld_q    <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      lane_a_q    <= '0;
      lane_b_q    <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      rd_vld_q    <= mem_rd_en_q;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      lane_a_q    <= lane_a_d;
      lane_b_q    <= lane_b_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign MemRdEn  = mem_rd_en_q;
  assign MemAddr  = mem_addr_q;
  assign LaneA    = lane_a_q;
  assign LaneB    = lane_b_q;
  assign PosX     = pos_x_q;
  assign PosY     = pos_y_q;
  assign OutValid = out_valid_q;
  assign OutLast  = out_last_q;

endmodule

// File: tb/tb_sad_operand_feeder.sv
// Bench for sad_operand_feeder: a 6x5 frame instance exercised by randomized passes and a
// 4x4 frame instance with a single candidate; memory returns the low address byte.
module tb_sad_operand_feeder;

  localparam int FW  = 6;
  localparam int FH  = 5;
  localparam int FB  = 16;
  localparam int AW  = 13;
  localparam int PW  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, busy, done, rd_en, out_valid, out_ready, out_last;
  logic [AW-1:0]   addr;
  logic [PW-1:0]   rd_data;
  logic [16*PW-1:0] lane_a, lane_b;
  logic [15:0]     posx, posy;

  logic            s_start, s_busy, s_done, s_rd_en, s_out_valid, s_out_ready, s_out_last;
  logic [AW-1:0]   s_addr;
  logic [PW-1:0]   s_rd_data;
  logic [16*PW-1:0] s_lane_a, s_lane_b;
  logic [15:0]     s_posx, s_posy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sad_operand_feeder #(
    .PIX_W(PW), .FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .WIN_BASE(0), .FRAME_BASE(FB)
  ) dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .Busy(busy), .Done(done),
    .MemRdEn(rd_en), .MemAddr(addr), .MemRdData(rd_data),
    .LaneA(lane_a), .LaneB(lane_b), .PosX(posx), .PosY(posy),
    .OutValid(out_valid), .OutReady(out_ready), .OutLast(out_last)
  );

  sad_operand_feeder #(
    .PIX_W(PW), .FRAME_W(4), .FRAME_H(4), .ADDR_W(AW), .WIN_BASE(0), .FRAME_BASE(FB)
  ) dut_small (
    .Clk(clk), .Reset(rst_n), .Start(s_start), .Busy(s_busy), .Done(s_done),
    .MemRdEn(s_rd_en), .MemAddr(s_addr), .MemRdData(s_rd_data),
    .LaneA(s_lane_a), .LaneB(s_lane_b), .PosX(s_posx), .PosY(s_posy),
    .OutValid(s_out_valid), .OutReady(s_out_ready), .OutLast(s_out_last)
  );

  // Pixel memory contents: value at address a is a[7:0]; one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en)   rd_data   <= addr[7:0];
    if (s_rd_en) s_rd_data <= s_addr[7:0];
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_lane_a();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = 8'(k);
    return r;
  endfunction

  function automatic logic [127:0] exp_lane_b(input int x, input int y, input int w);
    logic [127:0] r;
    int v;
    for (int k = 0; k < 16; k++) begin
      v = FB + (y + k / 4) * w + x + k % 4;
      r[k*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_rd_en"}, rd_en, 0);
    check_eq({pfx, "_addr"}, addr, 0);
    check_eq({pfx, "_lane_a"}, lane_a, 0);
    check_eq({pfx, "_lane_b"}, lane_b, 0);
    check_eq({pfx, "_posx"}, posx, 0);
    check_eq({pfx, "_posy"}, posy, 0);
    check_eq({pfx, "_valid"}, out_valid, 0);
    check_eq({pfx, "_last"}, out_last, 0);
  endtask

  task automatic run_pass(input bit rand_rdy, input bit rand_start, input int abort_idx,
                          input bit chk_timing, input bit stall_one);
    int idx = 0, cyc = 0, rd_cnt = 0, stall = 0, fcyc = 0;
    int npos = (FW - 3) * (FH - 3);
    bit seen = 0, fin = 0, hs;
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0; cyc = 1;
    if (chk_timing) begin
      check_eq("rd_en_first", rd_en, 1);
      check_eq("addr_first", addr, 0);
    end
    while (!fin && cyc < 4000) begin
      if (rd_en) rd_cnt++;
      check_eq("done_low", done, 0);
      check_eq("busy_high", busy, 1);
      if (out_valid) begin
        check_eq("no_rd_present", rd_en, 0);
        if (!seen && chk_timing) begin
          check_eq("first_valid_cycle", cyc, 35);
          check_eq("rd_cycles", rd_cnt, 32);
        end
        seen = 1;
        fcyc = 0;
        check_eq("posx", posx, idx % (FW - 3));
        check_eq("posy", posy, idx / (FW - 3));
        check_eq("lane_a", lane_a, exp_lane_a());
        check_eq("lane_b", lane_b, exp_lane_b(idx % (FW - 3), idx / (FW - 3), FW));
        check_eq("out_last", out_last, (idx == npos - 1));
      end else begin
        fcyc++;
      end
      if (abort_idx == idx && !out_valid && fcyc == 6) begin
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("abort");
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("abort_no_done", done, 0);
          check_eq("abort_idle_busy", busy, 0);
        end
        return;
      end
      if (stall_one && idx == 1 && stall < 10) begin
        out_ready = 1'b0;
        if (out_valid) stall++;
      end else if (rand_rdy) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready = 1'b1;
      end
      start = rand_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      hs = out_valid && out_ready;
      @(negedge clk); cyc++;
      if (hs) begin
        idx++;
        if (idx == npos) begin
          start = 1'b0;
          out_ready = 1'b0;
          check_eq("done_pulse", done, 1);
          check_eq("busy_fin", busy, 0);
          check_eq("valid_fin", out_valid, 0);
          @(negedge clk);
          check_eq("done_one_cycle", done, 0);
          check_eq("lane_a_retained", lane_a, exp_lane_a());
          fin = 1;
        end
      end
    end
    check_eq("pass_complete", fin, 1);
    check_eq("pos_count", idx, npos);
  endtask

  initial begin
    int wait_cyc;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; s_start = 1'b0; s_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_pass(1'b0, 1'b0, -1, 1'b1, 1'b0);
    run_pass(1'b0, 1'b0, -1, 1'b0, 1'b1);
    run_pass(1'b1, 1'b1, -1, 1'b0, 1'b0);
    run_pass(1'b1, 1'b1, -1, 1'b0, 1'b1);
    run_pass(1'b0, 1'b0, 2, 1'b0, 1'b0);
    run_pass(1'b0, 1'b0, -1, 1'b1, 1'b0);

    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    wait_cyc = 0;
    while (!s_out_valid && wait_cyc < 200) begin
      check_eq("s_done_low", s_done, 0);
      @(negedge clk); wait_cyc++;
    end
    check_eq("s_valid_seen", s_out_valid, 1);
    check_eq("s_posx", s_posx, 0);
    check_eq("s_posy", s_posy, 0);
    check_eq("s_last", s_out_last, 1);
    check_eq("s_lane_a", s_lane_a, exp_lane_a());
    check_eq("s_lane_b", s_lane_b, exp_lane_b(0, 0, 4));
    s_out_ready = 1'b1;
    @(negedge clk); s_out_ready = 1'b0;
    check_eq("s_done", s_done, 1);
    check_eq("s_valid_drop", s_out_valid, 0);
    check_eq("s_busy_fin", s_busy, 0);
    @(negedge clk);
    check_eq("s_done_once", s_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
